// File: rtl/binning_pkg.sv
// Shared types, widths and helpers for the NxN binning filter.
// AW/acc_t describe the default configuration; instances derive their own width with acc_w().
package binning_pkg;

  localparam int LATENCY = 3;

  function automatic int clog2_bin(input int bin);
    case (bin)
      2:       return 1;
      4:       return 2;
      8:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int acc_w(input int pixel_width, input int bin);
    return pixel_width + 2 * clog2_bin(bin);
  endfunction

  localparam int AW = acc_w(8, 2);

  typedef logic [AW-1:0] acc_t;

  typedef enum logic {
    BIN_AVG = 1'b0,
    BIN_SUM = 1'b1
  } bin_mode_e;

endpackage

// File: rtl/binning_line_ram.sv
// Line buffer of partial block sums, one entry per horizontal group.
// Registered read, 1-clock latency; no flow control, contents undefined after reset.
module binning_line_ram #(
  parameter int DEPTH  = 2048,
  parameter int WIDTH  = 10,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_dat,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
    if (rd_en) rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/binning_nxn.sv
// Sums or averages non-overlapping BIN x BIN blocks per channel of a de/hs/vs stream.
// 3-clock latency from the last block pixel to de_o; no backpressure, one pixel per clock accepted.
module binning_nxn
  import binning_pkg::*;
#(
  parameter int BIN           = 2,
  parameter int PIXEL_WIDTH   = 8,
  parameter int CH_COUNT      = 1,
  parameter int LINE_SIZE_MAX = 4096,
  parameter int DE_SPARSE     = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            bypass,
  input  logic                            mode_i,
  input  logic [PIXEL_WIDTH*CH_COUNT-1:0] di_i,
  input  logic                            de_i,
  input  logic                            hs_i,
  input  logic                            vs_i,
  output logic [PIXEL_WIDTH*CH_COUNT-1:0] do_o,
  output logic                            de_o,
  output logic                            hs_o,
  output logic                            vs_o
);

  localparam int PW     = PIXEL_WIDTH;
  localparam int LB     = clog2_bin(BIN);
  localparam int ACC_W  = acc_w(PIXEL_WIDTH, BIN);
  localparam int NGRP   = LINE_SIZE_MAX / BIN;
  localparam int ADDR_W = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int GW     = $clog2(NGRP + 1);

  localparam logic [GW-1:0]    GRP_SAT = GW'(NGRP);
  localparam logic [LB-1:0]    LAST    = LB'(BIN - 1);
  localparam logic [ACC_W-1:0] PIX_MAX = {{(ACC_W-PW){1'b0}}, {PW{1'b1}}};

  logic                        vs_q, hs_q, frame_act;
  bin_mode_e                   mode_q;
  logic [LB-1:0]               col_cnt, row_cnt, col_base, row_base;
  logic [GW-1:0]               grp_idx, grp_base;
  logic [CH_COUNT*ACC_W-1:0]   hacc, hsum, total, ram_rd_dat, ram_wr_dat, s1_tot;
  logic [CH_COUNT*PW-1:0]      s1_pix, s2_pix, byp_d1, byp_d2;
  logic                        vs_rise, hs_rise, beat, blk_done, ram_wr_en, ram_rd_en;
  logic                        s1_vld, s2_vld;
  logic [1:0]                  byp_vld;
  logic [LATENCY-1:0]          hs_d, vs_d;

  assign vs_rise  = vs_i & ~vs_q;
  assign hs_rise  = hs_i & ~hs_q;

  // Frame/line boundaries take effect in the same cycle, so a pixel that
  // coincides with an edge is already counted against the cleared position.
  assign col_base = (vs_rise | hs_rise) ? '0 : col_cnt;
  assign grp_base = (vs_rise | hs_rise) ? '0 : grp_idx;
  assign row_base = vs_rise ? '0 : (hs_rise ? row_cnt + 1'b1 : row_cnt);

  assign beat     = de_i & vs_i & (frame_act | vs_rise) & ~bypass & (grp_base != GRP_SAT);
  assign blk_done = beat & (col_base == LAST);

  assign ram_rd_en  = beat & (col_base == '0);
  assign ram_wr_en  = blk_done & (row_base != LAST);
  assign ram_wr_dat = (row_base == '0) ? hsum : total;

  for (genvar c = 0; c < CH_COUNT; c++) begin : g_ch
    logic [ACC_W-1:0] px, hv, tot_c;
    assign px    = {{(ACC_W-PW){1'b0}}, di_i[c*PW +: PW]};
    assign hv    = (col_base == '0) ? px : hacc[c*ACC_W +: ACC_W] + px;
    assign hsum[c*ACC_W +: ACC_W]  = hv;
    assign total[c*ACC_W +: ACC_W] = ram_rd_dat[c*ACC_W +: ACC_W] + hv;
    assign tot_c = s1_tot[c*ACC_W +: ACC_W];
    // Average is the total shifted down by 2*LB, i.e. its top PW bits.
    assign s1_pix[c*PW +: PW] = (mode_q == BIN_SUM)
                              ? ((tot_c > PIX_MAX) ? {PW{1'b1}} : tot_c[PW-1:0])
                              : tot_c[2*LB +: PW];
  end

  binning_line_ram #(
    .DEPTH  (NGRP),
    .WIDTH  (CH_COUNT*ACC_W),
    .ADDR_W (ADDR_W)
  ) u_line_ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr (grp_base[ADDR_W-1:0]),
    .wr_dat  (ram_wr_dat),
    .rd_en   (ram_rd_en),
    .rd_addr (grp_base[ADDR_W-1:0]),
    .rd_dat  (ram_rd_dat)
  );

  // Edge history resets high so a frame already in progress at reset release
  // is not mistaken for a new frame start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_q      <= 1'b1;
      hs_q      <= 1'b1;
      frame_act <= 1'b0;
      mode_q    <= BIN_AVG;
      col_cnt   <= '0;
      row_cnt   <= '0;
      grp_idx   <= '0;
      hacc      <= '0;
    end else begin
      vs_q <= vs_i;
      hs_q <= hs_i;
      if (vs_rise) begin
        frame_act <= 1'b1;
        mode_q    <= bin_mode_e'(mode_i);
      end else if (!vs_i) begin
        frame_act <= 1'b0;
      end
      if (!bypass) begin
        col_cnt <= beat ? col_base + 1'b1 : col_base;
        row_cnt <= row_base;
        grp_idx <= blk_done ? grp_base + 1'b1 : grp_base;
        if (beat) hacc <= hsum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld  <= 1'b0;
      s1_tot  <= '0;
      s2_vld  <= 1'b0;
      s2_pix  <= '0;
      byp_vld <= '0;
      byp_d1  <= '0;
      byp_d2  <= '0;
      de_o    <= 1'b0;
      do_o    <= '0;
      hs_d    <= '1;
      vs_d    <= '0;
    end else begin
      s1_vld  <= blk_done & (row_base == LAST);
      if (blk_done) s1_tot <= total;
      s2_vld  <= s1_vld;
      s2_pix  <= s1_pix;
      byp_vld <= {byp_vld[0], de_i};
      byp_d1  <= di_i;
      byp_d2  <= byp_d1;
      de_o    <= bypass ? byp_vld[1] : s2_vld;
      do_o    <= bypass ? byp_d2 : s2_pix;
      hs_d    <= {hs_d[LATENCY-2:0], hs_i};
      vs_d    <= {vs_d[LATENCY-2:0], vs_i};
    end
  end

  assign hs_o = hs_d[LATENCY-1];
  assign vs_o = vs_d[LATENCY-1];

endmodule

// File: tb/tb_binning_nxn.sv
// Drives three binning_nxn configurations with one stream and checks them
// against a frame-level block-sum model (values, output cycle, counts, hs/vs delay).
module tb_binning_nxn;

  typedef struct {
    int          cyc;
    logic [23:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, bypass, mode_i, de_i, hs_i, vs_i;
  logic [7:0]  di_a, do_a, do_b;
  logic [23:0] di_c, do_c;
  logic        de_a, de_b, de_c, hs_a, hs_b, hs_c, vs_a, vs_b, vs_c;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   cnt [3] = '{0, 0, 0};
  exp_t q [3][$];
  int   pix [3][16][16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  binning_nxn #(.BIN(2), .LINE_SIZE_MAX(8)) u_a (
    .clk(clk), .rst(rst), .bypass(bypass), .mode_i(mode_i), .di_i(di_a), .de_i(de_i),
    .hs_i(hs_i), .vs_i(vs_i), .do_o(do_a), .de_o(de_a), .hs_o(hs_a), .vs_o(vs_a));
  binning_nxn #(.BIN(4)) u_b (
    .clk(clk), .rst(rst), .bypass(bypass), .mode_i(mode_i), .di_i(di_a), .de_i(de_i),
    .hs_i(hs_i), .vs_i(vs_i), .do_o(do_b), .de_o(de_b), .hs_o(hs_b), .vs_o(vs_b));
  binning_nxn #(.BIN(2), .CH_COUNT(3)) u_c (
    .clk(clk), .rst(rst), .bypass(bypass), .mode_i(mode_i), .di_i(di_c), .de_i(de_i),
    .hs_i(hs_i), .vs_i(vs_i), .do_o(do_c), .de_o(de_c), .hs_o(hs_c), .vs_o(vs_c));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected output for every block whose last pixel was just driven.
  task automatic model_push(input int x, input int y, input int byp, input int md);
    exp_t e;
    e.cyc = cyc + 3;
    if (byp != 0) begin
      e.val = {16'b0, di_a};
      q[0].push_back(e);
      q[1].push_back(e);
      e.val = di_c;
      q[2].push_back(e);
      return;
    end
    for (int i = 0; i < 3; i++) begin
      int b, lsm, nch, s, r;
      b   = (i == 1) ? 4 : 2;
      lsm = (i == 0) ? 8 : 4096;
      nch = (i == 2) ? 3 : 1;
      if ((x % b == b - 1) && (y % b == b - 1) && (x < lsm)) begin
        e.val = '0;
        for (int ch = 0; ch < nch; ch++) begin
          s = 0;
          for (int yy = y - b + 1; yy <= y; yy++)
            for (int xx = x - b + 1; xx <= x; xx++)
              s += pix[ch][yy][xx];
          r = (md != 0) ? ((s > 255) ? 255 : s) : s / (b * b);
          e.val[ch*8 +: 8] = 8'(r);
        end
        q[i].push_back(e);
      end
    end
  endtask

  // pat: 0 = B x-ramp / G y-ramp / R 0xFF, 1 = random, 2 = constant 200.
  task automatic drive_frame(input int w, input int h, input int pat, input int md,
                             input int gmin, input int gmax, input int byp, input int abort_row);
    int c0 [3];
    for (int i = 0; i < 3; i++) c0[i] = cnt[i];
    de_i = 1'b0; hs_i = 1'b1; vs_i = 1'b0; bypass = (byp != 0); mode_i = (md != 0);
    repeat (4) tick();
    vs_i = 1'b1;
    repeat (2) tick();
    mode_i = (md == 0);
    for (int y = 0; y < h; y++) begin
      hs_i = 1'b0;
      tick();
      for (int x = 0; x < w; x++) begin
        if (y == abort_row && x == w / 2) begin
          de_i = 1'b0;
          repeat (6) tick();
          rst = 1'b0;
          #1;
          chk("rst_do_a", 32'(do_a), 0);
          chk("rst_de_a", 32'(de_a), 0);
          chk("rst_hs_a", 32'(hs_a), 1);
          chk("rst_vs_a", 32'(vs_a), 0);
          chk("rst_do_c", 32'(do_c), 0);
          repeat (2) tick();
          rst = 1'b1;
          // Still inside the interrupted frame: nothing may be produced.
          for (int k = 0; k < 10; k++) begin
            de_i = 1'b1; di_a = 8'($urandom); di_c = 24'($urandom); hs_i = (k == 5);
            tick();
          end
          de_i = 1'b0; hs_i = 1'b1; vs_i = 1'b0;
          repeat (8) tick();
          return;
        end
        for (int ch = 0; ch < 3; ch++)
          pix[ch][y][x] = (pat == 2) ? 200 :
                          (pat == 1) ? int'($urandom_range(0, 255)) :
                          (ch == 0) ? x : (ch == 1) ? y : 255;
        di_a = 8'(pix[0][y][x]);
        di_c = {8'(pix[2][y][x]), 8'(pix[1][y][x]), 8'(pix[0][y][x])};
        de_i = 1'b1;
        model_push(x, y, byp, md);
        tick();
        de_i = 1'b0;
        di_a = 8'($urandom);
        repeat ($urandom_range(gmin, gmax)) tick();
      end
      hs_i = 1'b1;
      repeat (3) tick();
    end
    vs_i = 1'b0;
    repeat (8) tick();
    if (byp != 0) begin
      chk("cnt_byp_a", 32'(cnt[0] - c0[0]), 32'(w * h));
      chk("cnt_byp_c", 32'(cnt[2] - c0[2]), 32'(w * h));
    end else begin
      chk("cnt_a", 32'(cnt[0] - c0[0]), 32'(((w < 8 ? w : 8) / 2) * (h / 2)));
      chk("cnt_b", 32'(cnt[1] - c0[1]), 32'((w / 4) * (h / 4)));
      chk("cnt_c", 32'(cnt[2] - c0[2]), 32'((w / 2) * (h / 2)));
    end
    bypass = 1'b0;
  endtask

  // Output monitor, sampled mid-cycle.
  logic [2:0]  hs_h = '1;
  logic [2:0]  vs_h = '0;
  int          up = 0;
  logic        de_v [3];
  logic [23:0] do_v [3];
  always @(negedge clk) begin
    if (!rst) begin
      up = 0;
    end else begin
      if (up >= 3) begin
        chk("hs_a", 32'(hs_a), 32'(hs_h[2]));
        chk("hs_b", 32'(hs_b), 32'(hs_h[2]));
        chk("hs_c", 32'(hs_c), 32'(hs_h[2]));
        chk("vs_a", 32'(vs_a), 32'(vs_h[2]));
        chk("vs_b", 32'(vs_b), 32'(vs_h[2]));
        chk("vs_c", 32'(vs_c), 32'(vs_h[2]));
      end
      up++;
      de_v = '{de_a, de_b, de_c};
      do_v = '{{16'b0, do_a}, {16'b0, do_b}, do_c};
      for (int i = 0; i < 3; i++) begin
        while (q[i].size() != 0 && q[i][0].cyc < cyc) begin
          chk($sformatf("missing_de%0d", i), 32'(cyc), 32'(q[i][0].cyc));
          void'(q[i].pop_front());
        end
        if (de_v[i]) begin
          exp_t e;
          cnt[i]++;
          chk($sformatf("extra_de%0d", i), 32'(q[i].size() != 0), 1);
          if (q[i].size() != 0) begin
            e = q[i].pop_front();
            chk($sformatf("lat%0d", i), 32'(cyc), 32'(e.cyc));
            chk($sformatf("dat%0d", i), 32'(do_v[i]), 32'(e.val));
          end
        end
      end
    end
    hs_h = {hs_h[1:0], hs_i};
    vs_h = {vs_h[1:0], vs_i};
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got cycle %0d, want end of test", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; bypass = 1'b0; mode_i = 1'b0; de_i = 1'b0;
    hs_i = 1'b1; vs_i = 1'b0; di_a = '0; di_c = '0;
    repeat (2) tick();
    chk("init_do_a", 32'(do_a), 0);
    chk("init_de_a", 32'(de_a), 0);
    chk("init_hs_a", 32'(hs_a), 1);
    chk("init_vs_a", 32'(vs_a), 0);
    chk("init_de_b", 32'(de_b), 0);
    chk("init_do_c", 32'(do_c), 0);
    rst = 1'b1;
    repeat (3) tick();

    drive_frame(8, 8, 0, 0, 0, 0, 0, -1);   // ramp, average, two frames
    drive_frame(8, 8, 0, 0, 0, 0, 0, -1);
    drive_frame(8, 8, 0, 1, 0, 0, 0, -1);   // ramp, sum
    drive_frame(8, 8, 2, 1, 0, 0, 0, -1);   // saturating sum
    drive_frame(7, 7, 1, 0, 1, 2, 0, -1);   // partial column/row, sparse de
    drive_frame(12, 8, 1, 1, 0, 1, 0, -1);  // exceeds line size of instance a
    drive_frame(8, 8, 0, 0, 0, 0, 0, 3);    // reset mid row 3
    drive_frame(8, 8, 0, 0, 0, 0, 0, -1);
    drive_frame(8, 8, 1, 0, 0, 1, 1, -1);   // bypass
    for (int f = 0; f < 4; f++)
      drive_frame($urandom_range(7, 12), $urandom_range(5, 8), 1,
                  $urandom_range(0, 1), 0, 2, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
